// File: rtl/onewire_rom_responder.sv
// 1-Wire slave that answers reset with presence, takes a command byte
// and streams its 64-bit ROM ID when asked with Read ROM.
module onewire_rom_responder #(
    parameter logic [63:0] ROM_ID       = 64'hA200_0000_0ABC_DE28,
    parameter logic [7:0]  CMD_READ_ROM = 8'h33,
    parameter int          RESET_MIN    = 480,
    parameter int          PRES_WAIT    = 30,
    parameter int          PRES_LEN     = 120,
    parameter int          SAMPLE_PT    = 30,
    parameter int          HOLD_ZERO    = 45,
    parameter int          CNT_W        = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bus,
    output logic       slave_pull_low,
    output logic       cmd_valid,
    output logic [7:0] cmd_byte,
    output logic       rom_sent,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_LOW,
        S_PRES_WAIT,
        S_PRESENCE,
        S_RX_CMD,
        S_TX_ROM,
        S_WAIT_RST
    } state_t;

    localparam logic [CNT_W-1:0] RST_CNT = CNT_W'(RESET_MIN);
    localparam logic [CNT_W-1:0] PW_CNT  = CNT_W'(PRES_WAIT);
    localparam logic [CNT_W-1:0] PL_CNT  = CNT_W'(PRES_LEN);
    localparam logic [CNT_W-1:0] SP_CNT  = CNT_W'(SAMPLE_PT);
    localparam logic [CNT_W-1:0] HZ_CNT  = CNT_W'(HOLD_ZERO);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state_q;
    logic             bus_m_q;
    logic             bus_s_q;
    logic             bus_p_q;
    logic [1:0]       flush_q;
    logic [CNT_W-1:0] low_cnt_q;
    logic [CNT_W-1:0] cnt_q;
    logic [5:0]       idx_q;
    logic             in_slot_q;
    logic [7:0]       cmd_sh_q;
    logic [7:0]       cmd_byte_q;
    logic             pull_q;
    logic             cmd_valid_q;
    logic             rom_sent_q;
    logic             busy_q;

    logic             mask;
    logic             fall;
    logic             rst_seen;
    logic             abortable;
    logic [7:0]       cmd_next;

    // Our own drive and its synchronizer tail must not look like master activity
    assign mask      = pull_q | (flush_q != 2'd0);
    assign fall      = bus_p_q & ~bus_s_q & ~mask;
    assign rst_seen  = (low_cnt_q == RST_CNT);
    assign cmd_next  = {bus_s_q, cmd_sh_q[7:1]};
    assign abortable = (state_q == S_PRES_WAIT) || (state_q == S_RX_CMD) ||
                       (state_q == S_TX_ROM)    || (state_q == S_WAIT_RST);

    assign slave_pull_low = pull_q;
    assign cmd_valid      = cmd_valid_q;
    assign cmd_byte       = cmd_byte_q;
    assign rom_sent       = rom_sent_q;
    assign busy           = busy_q;

    // Two-flop synchronizer plus one delayed copy for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_m_q <= 1'b1;
            bus_s_q <= 1'b1;
            bus_p_q <= 1'b1;
        end else begin
            bus_m_q <= bus;
            bus_s_q <= bus_m_q;
            bus_p_q <= bus_s_q;
        end
    end

    // Flush window after release and the saturating low-time counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_q   <= 2'd0;
            low_cnt_q <= '0;
        end else begin
            if (pull_q) begin
                flush_q <= 2'd2;
            end else if (flush_q != 2'd0) begin
                flush_q <= flush_q - 2'd1;
            end
            if (mask || bus_s_q) begin
                low_cnt_q <= '0;
            end else if (low_cnt_q != RST_CNT) begin
                low_cnt_q <= low_cnt_q + ONE;
            end
        end
    end

    // Protocol state machine with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            in_slot_q   <= 1'b0;
            cmd_sh_q    <= '0;
            cmd_byte_q  <= '0;
            pull_q      <= 1'b0;
            cmd_valid_q <= 1'b0;
            rom_sent_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            cmd_valid_q <= 1'b0;
            rom_sent_q  <= 1'b0;
            if (abortable && rst_seen) begin
                state_q   <= S_RST_LOW;
                pull_q    <= 1'b0;
                idx_q     <= '0;
                in_slot_q <= 1'b0;
                cnt_q     <= '0;
                cmd_sh_q  <= '0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (rst_seen) begin
                            state_q <= S_RST_LOW;
                            busy_q  <= 1'b1;
                        end
                    end
                    S_RST_LOW: begin
                        if (bus_s_q) begin
                            state_q <= S_PRES_WAIT;
                            cnt_q   <= ONE;
                        end
                    end
                    S_PRES_WAIT: begin
                        if (cnt_q == PW_CNT) begin
                            state_q <= S_PRESENCE;
                            pull_q  <= 1'b1;
                            cnt_q   <= ONE;
                        end else begin
                            cnt_q <= cnt_q + ONE;
                        end
                    end
                    S_PRESENCE: begin
                        if (cnt_q == PL_CNT) begin
                            state_q   <= S_RX_CMD;
                            pull_q    <= 1'b0;
                            idx_q     <= '0;
                            in_slot_q <= 1'b0;
                            cnt_q     <= '0;
                        end else begin
                            cnt_q <= cnt_q + ONE;
                        end
                    end
                    S_RX_CMD: begin
                        if (!in_slot_q) begin
                            if (fall) begin
                                in_slot_q <= 1'b1;
                                cnt_q     <= ONE;
                            end
                        end else if (cnt_q == SP_CNT) begin
                            in_slot_q <= 1'b0;
                            cmd_sh_q  <= cmd_next;
                            idx_q     <= idx_q + 6'd1;
                            if (idx_q[2:0] == 3'd7) begin
                                idx_q       <= '0;
                                cmd_byte_q  <= cmd_next;
                                cmd_valid_q <= 1'b1;
                                if (cmd_next == CMD_READ_ROM) begin
                                    state_q <= S_TX_ROM;
                                end else begin
                                    state_q <= S_WAIT_RST;
                                end
                            end
                        end else begin
                            cnt_q <= cnt_q + ONE;
                        end
                    end
                    S_TX_ROM: begin
                        if (!in_slot_q) begin
                            if (fall) begin
                                in_slot_q <= 1'b1;
                                cnt_q     <= ONE;
                                pull_q    <= ~ROM_ID[idx_q];
                            end
                        end else if (cnt_q == HZ_CNT) begin
                            pull_q    <= 1'b0;
                            in_slot_q <= 1'b0;
                            idx_q     <= idx_q + 6'd1;
                            if (idx_q == 6'd63) begin
                                idx_q      <= '0;
                                rom_sent_q <= 1'b1;
                                state_q    <= S_WAIT_RST;
                            end
                        end else begin
                            cnt_q <= cnt_q + ONE;
                        end
                    end
                    S_WAIT_RST: begin
                        state_q <= S_WAIT_RST;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
